// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter that shares one 8N1 UART transmitter
// among N_REQ byte-stream requesters; a granted requester keeps the UART until its last byte.
module uart_tx_arb #(
    parameter int N_REQ   = 2,
    parameter int BUSY_TO = 8,
    parameter int IW      = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [IW-1:0]      grant_id,
    output logic               grant_lock,
    output logic               tx_err
);
    typedef enum logic [1:0] {S_ARB, S_SEND, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [7:0]    busy_cnt;
    logic [7:0]    hold_data;
    logic          hold_last;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          accept, byte_done, cnt_clr, cnt_inc;

    assign tx_data = hold_data;

    // While locked only the owner is eligible; otherwise scan circularly from rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        if (grant_lock) begin
            pick_found = req_valid[grant_id];
            pick_idx   = grant_id;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = IW'((int'(rr_ptr) + k) % N_REQ);
                if (!pick_found && req_valid[cand]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        sel_data = 8'h00;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_data = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_ARB;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        byte_done = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        tx_start  = 1'b0;
        tx_err    = 1'b0;
        req_ready = '0;
        case (state)
            S_ARB: begin
                // rst_n gate keeps req_ready low while reset is held
                if (pick_found && !tx_busy && rst_n) begin
                    accept              = 1'b1;
                    req_ready[pick_idx] = 1'b1;
                    state_nxt           = S_SEND;
                end
            end
            S_SEND: begin
                tx_start  = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (busy_cnt == 8'(BUSY_TO - 1)) begin
                    tx_err    = 1'b1;
                    byte_done = 1'b1;
                    state_nxt = S_ARB;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                    state_nxt = S_ARB;
                end
            end
            default: state_nxt = S_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            busy_cnt   <= 8'h00;
            hold_data  <= 8'h00;
            hold_last  <= 1'b0;
            grant_id   <= '0;
            grant_lock <= 1'b0;
        end else begin
            if (accept) begin
                hold_data  <= sel_data;
                hold_last  <= sel_last;
                grant_id   <= pick_idx;
                grant_lock <= 1'b1;
            end
            if (cnt_clr)      busy_cnt <= 8'h00;
            else if (cnt_inc) busy_cnt <= busy_cnt + 8'd1;
            // rr_ptr moves only when a whole message has gone out
            if (byte_done && hold_last) begin
                grant_lock <= 1'b0;
                rr_ptr     <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: rule-level cycle model plus directed scenarios with literal expectations.
module tb_uart_tx_arb;
    localparam int N        = 3;
    localparam int IW       = 2;
    localparam int BTO      = 8;
    localparam int BUSY_LEN = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic [7:0]     tx_data;
    logic           tx_start, tx_busy, tx_err, grant_lock;
    logic [IW-1:0]  grant_id;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit uart_dead = 1'b0;
    int ubusy     = 0;

    logic [8:0] q0[$], q1[$], q2[$];
    int         acc_id[$], acc_cyc[$], st_cyc[$], err_cyc[$];
    logic [7:0] st_data[$];
    int         busy_starts = 0;

    // rule-level model state
    bit         m_inflight, m_rose, m_lock, m_hlast;
    int         m_tacc, m_owner, m_rr;
    logic [7:0] m_hdata;

    logic [7:0] exp_sim[6] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
    int         exp_sid[6] = '{0, 0, 0, 1, 1, 1};
    int         exp_fair[6] = '{0, 1, 2, 0, 1, 2};

    uart_tx_arb #(.N_REQ(N), .BUSY_TO(BTO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .grant_id(grant_id), .grant_lock(grant_lock),
        .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    // UART peer: busy for BUSY_LEN cycles starting the cycle after tx_start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     ubusy <= 0;
        else if (tx_start && !uart_dead) ubusy <= BUSY_LEN;
        else if (ubusy > 0)             ubusy <= ubusy - 1;
    end
    assign tx_busy = (ubusy != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_on();
        @(posedge clk);
        #2 rst_n = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        acc_id.delete(); acc_cyc.delete(); st_cyc.delete(); err_cyc.delete(); st_data.delete();
    endtask

    task automatic reset_off();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // requesters: present queue heads, pop on an accepted handshake
    initial begin : drv
        logic [N-1:0] took;
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk);
            took = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (took[0]) void'(q0.pop_front());
            if (took[1]) void'(q1.pop_front());
            if (took[2]) void'(q2.pop_front());
            req_valid[0] = (q0.size() > 0);
            if (q0.size() > 0) {req_last[0], req_data[7:0]}   = q0[0];
            req_valid[1] = (q1.size() > 0);
            if (q1.size() > 0) {req_last[1], req_data[15:8]}  = q1[0];
            req_valid[2] = (q2.size() > 0);
            if (q2.size() > 0) {req_last[2], req_data[23:16]} = q2[0];
        end
    end

    // model + compare + event log, all on the falling edge
    always @(negedge clk) begin
        int e_idx;
        bit e_start, e_err, fin;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_tx_start", 32'(tx_start), 32'd0);
            check("rst_tx_data", 32'(tx_data), 32'd0);
            check("rst_grant_id", 32'(grant_id), 32'd0);
            check("rst_grant_lock", 32'(grant_lock), 32'd0);
            check("rst_tx_err", 32'(tx_err), 32'd0);
            m_inflight = 0; m_rose = 0; m_lock = 0; m_hlast = 0;
            m_owner = 0; m_rr = 0; m_tacc = 0; m_hdata = 8'h00;
        end else begin
            e_idx = -1;
            if (!m_inflight && !tx_busy) begin
                if (m_lock) begin
                    if (req_valid[IW'(m_owner)]) e_idx = m_owner;
                end else begin
                    for (int k = 0; k < N; k++)
                        if (e_idx < 0 && req_valid[IW'((m_rr + k) % N)]) e_idx = (m_rr + k) % N;
                end
            end
            e_start = m_inflight && (cyc == m_tacc + 1);
            e_err   = m_inflight && !m_rose && !tx_busy && (cyc == m_tacc + 1 + BTO);
            check("req_ready", 32'(req_ready), (e_idx < 0) ? 32'd0 : 32'(1 << e_idx));
            check("tx_start", 32'(tx_start), 32'(e_start));
            if (e_start) check("tx_data", 32'(tx_data), 32'(m_hdata));
            check("tx_err", 32'(tx_err), 32'(e_err));
            check("grant_id", 32'(grant_id), 32'(m_owner));
            check("grant_lock", 32'(grant_lock), 32'(m_lock));

            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin acc_id.push_back(i); acc_cyc.push_back(cyc); end
            if (tx_start) begin
                st_cyc.push_back(cyc); st_data.push_back(tx_data);
                if (tx_busy) busy_starts++;
            end
            if (tx_err) err_cyc.push_back(cyc);

            if (e_idx >= 0) begin
                m_inflight = 1; m_rose = 0; m_tacc = cyc; m_owner = e_idx; m_lock = 1;
                m_hdata = req_data[8*e_idx +: 8];
                m_hlast = req_last[e_idx];
            end else if (m_inflight && cyc >= m_tacc + 2) begin
                fin = e_err;
                if (!e_err) begin
                    if (!m_rose && tx_busy)      m_rose = 1;
                    else if (m_rose && !tx_busy) fin = 1;
                end
                if (fin) begin
                    m_inflight = 0;
                    if (m_hlast) begin m_lock = 0; m_rr = (m_owner + 1) % N; end
                end
            end
        end
        cyc++;
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("init_tx_data", 32'(tx_data), 32'd0);
        check("init_grant_lock", 32'(grant_lock), 32'd0);
        check("init_req_ready", 32'(req_ready), 32'd0);

        // single byte, then rr_ptr=1 lets requester 1 win a tie
        reset_on();
        q0.push_back({1'b1, 8'h55});
        reset_off();
        run(30);
        check("single_acc_n", 32'(acc_id.size()), 32'd1);
        check("single_acc_id", 32'(acc_id[0]), 32'd0);
        check("single_start_lat", 32'(st_cyc[0] - acc_cyc[0]), 32'd1);
        check("single_data", 32'(st_data[0]), 32'h55);
        check("single_lock_end", 32'(grant_lock), 32'd0);
        check("single_gid", 32'(grant_id), 32'd0);
        q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h22});
        run(40);
        check("rr_first", 32'(acc_id[1]), 32'd1);
        check("rr_second", 32'(acc_id[2]), 32'd0);

        // two simultaneous 3-byte messages never interleave
        reset_on();
        q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
        q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b0, 8'hB1}); q1.push_back({1'b1, 8'hB2});
        reset_off();
        run(110);
        check("sim_n", 32'(st_data.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("sim_data", 32'(st_data[i]), 32'(exp_sim[i]));
            check("sim_id", 32'(acc_id[i]), 32'(exp_sid[i]));
        end
        check("b2b_gap", 32'(acc_cyc[1] - st_cyc[0]), 32'd12);
        check("b_after_a2", 32'(acc_cyc[3] - st_cyc[2]), 32'd12);

        // fairness with three always-valid single-byte requesters
        reset_on();
        for (int r = 0; r < 2; r++) begin
            q0.push_back({1'b1, 8'h30}); q1.push_back({1'b1, 8'h31}); q2.push_back({1'b1, 8'h32});
        end
        reset_off();
        run(110);
        check("fair_n", 32'(acc_id.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("fair_id", 32'(acc_id[i]), 32'(exp_fair[i]));

        // UART never raises busy: timeout then rotate
        uart_dead = 1'b1;
        reset_on();
        q0.push_back({1'b1, 8'h77});
        q1.push_back({1'b1, 8'h88});
        reset_off();
        run(40);
        check("to_err_n", 32'(err_cyc.size()), 32'd2);
        check("to_err_lat", 32'(err_cyc[0] - acc_cyc[0]), 32'd9);
        check("to_next_id", 32'(acc_id[1]), 32'd1);
        check("to_next_lat", 32'(acc_cyc[1] - err_cyc[0]), 32'd1);
        check("to_lock_end", 32'(grant_lock), 32'd0);
        uart_dead = 1'b0;

        // asynchronous reset during byte 2 of 3
        reset_on();
        q0.push_back({1'b0, 8'hC0}); q0.push_back({1'b0, 8'hC1}); q0.push_back({1'b1, 8'hC2});
        q1.push_back({1'b1, 8'hD0});
        reset_off();
        for (int i = 0; i < 100 && st_cyc.size() < 2; i++) @(posedge clk);
        check("mid_reached", 32'(st_cyc.size()), 32'd2);
        run(4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_req_ready", 32'(req_ready), 32'd0);
        check("mid_tx_start", 32'(tx_start), 32'd0);
        check("mid_tx_data", 32'(tx_data), 32'd0);
        check("mid_grant_id", 32'(grant_id), 32'd0);
        check("mid_grant_lock", 32'(grant_lock), 32'd0);
        check("mid_tx_err", 32'(tx_err), 32'd0);
        acc_id.delete(); acc_cyc.delete(); st_cyc.delete(); st_data.delete(); err_cyc.delete();
        reset_off();
        run(60);
        check("mid_after_n", 32'(acc_id.size()), 32'd2);
        check("mid_after_id0", 32'(acc_id[0]), 32'd0);
        check("mid_after_d0", 32'(st_data[0]), 32'hC2);
        check("mid_after_id1", 32'(acc_id[1]), 32'd1);

        // owner stalls mid-message: requester 1 must wait
        reset_on();
        q0.push_back({1'b0, 8'hE0});
        q1.push_back({1'b1, 8'hF0});
        reset_off();
        run(40);
        check("stall_acc_n", 32'(acc_id.size()), 32'd1);
        check("stall_start_n", 32'(st_cyc.size()), 32'd1);
        check("stall_lock", 32'(grant_lock), 32'd1);
        check("stall_gid", 32'(grant_id), 32'd0);
        q0.push_back({1'b1, 8'hE1});
        run(50);
        check("stall_n", 32'(st_data.size()), 32'd3);
        check("stall_d1", 32'(st_data[1]), 32'hE1);
        check("stall_d2", 32'(st_data[2]), 32'hF0);
        check("stall_id2", 32'(acc_id[2]), 32'd1);

        check("start_while_busy", 32'(busy_starts), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
